// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select codes, datapath widths and the ID/EX slot types.
// Holds: XLEN, REG_IDX_W, ALU_* select constants, ctrl_t control bundle,
// slot_t (the full contents of the ID/EX pipeline register).
package alu_pkg;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_BEQ = 4'b0111;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic [3:0]           alu_sel;
        logic                 alu_src;
        ctrl_t                ctrl;
    } slot_t;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational operand bypass for one source register.
// Ports: idx/reg_data (registered index and value), ex_mem_* and mem_wb_*
// (bypass sources, EX/MEM has priority), fwd_data (selected operand).
module forward_unit
    import alu_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [XLEN-1:0]      reg_data,
    input  logic [REG_IDX_W-1:0] ex_mem_rd,
    input  logic                 ex_mem_reg_write,
    input  logic [XLEN-1:0]      ex_mem_result,
    input  logic [REG_IDX_W-1:0] mem_wb_rd,
    input  logic                 mem_wb_reg_write,
    input  logic [XLEN-1:0]      mem_wb_result,
    output logic [XLEN-1:0]      fwd_data
);
    // x0 is hardwired zero, so a pending write to it must never be bypassed.
    logic nz;
    assign nz = idx != '0;

    always_comb begin
        fwd_data = (nz && ex_mem_reg_write && ex_mem_rd == idx) ? ex_mem_result :
                   (nz && mem_wb_reg_write && mem_wb_rd == idx) ? mem_wb_result : reg_data;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU, with forwarding and load-use hazard detection.
// Ports: clk/rst (sync active-high), id_* decoded instruction, stall/flush,
// ex_mem_*/mem_wb_* bypass sources, alu_in1/alu_in2/alu_sel ALU drive,
// ex_store_data forwarded rs2, ex_* registered control, hazard (combinational).
// Build option: define FORWARDING_EN to enable the bypass muxes; without it the
// operands come from the register file only and hazard covers every RAW match.
module id_ex_stage
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [3:0]           id_alu_sel,
    input  logic                 id_alu_src,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_branch,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [REG_IDX_W-1:0] ex_mem_rd,
    input  logic                 ex_mem_reg_write,
    input  logic [XLEN-1:0]      ex_mem_result,
    input  logic [REG_IDX_W-1:0] mem_wb_rd,
    input  logic                 mem_wb_reg_write,
    input  logic [XLEN-1:0]      mem_wb_result,
    output logic [XLEN-1:0]      alu_in1,
    output logic [XLEN-1:0]      alu_in2,
    output logic [3:0]           alu_sel,
    output logic [XLEN-1:0]      ex_store_data,
    output logic                 ex_valid,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_branch,
    output logic                 hazard
);
    slot_t           s;
    slot_t           id_slot;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            ex_hit;

    always_comb begin
        id_slot                = '0;
        id_slot.valid          = 1'b1;
        id_slot.rs1            = id_rs1;
        id_slot.rs2            = id_rs2;
        id_slot.rd             = id_rd;
        id_slot.rs1_data       = id_rs1_data;
        id_slot.rs2_data       = id_rs2_data;
        id_slot.imm            = id_imm;
        id_slot.alu_sel        = id_alu_sel;
        id_slot.alu_src        = id_alu_src;
        id_slot.ctrl.reg_write = id_reg_write;
        id_slot.ctrl.mem_read  = id_mem_read;
        id_slot.ctrl.mem_write = id_mem_write;
        id_slot.ctrl.branch    = id_branch;
    end

    // Bubbles are all-zero slots; stall outranks the hazard so a held stage is never bubbled.
    always_ff @(posedge clk) begin
        if (rst || flush)
            s <= '0;
        else if (!stall)
            s <= (hazard || !id_valid) ? '0 : id_slot;
    end

    assign ex_hit = s.valid && s.rd != '0 && (s.rd == id_rs1 || s.rd == id_rs2);

`ifdef FORWARDING_EN
    // Only a load in EX cannot be bypassed in time; everything else forwards.
    assign hazard = id_valid && s.ctrl.mem_read && ex_hit;

    forward_unit u_fwd_rs1 (
        .idx(s.rs1), .reg_data(s.rs1_data),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_result(ex_mem_result),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_result(mem_wb_result),
        .fwd_data(rs1_fwd)
    );

    forward_unit u_fwd_rs2 (
        .idx(s.rs2), .reg_data(s.rs2_data),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_result(ex_mem_result),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_result(mem_wb_result),
        .fwd_data(rs2_fwd)
    );
`else
    // Without bypassing, wait until the producer has left EX/MEM; the write-first
    // register file covers the MEM/WB case.
    logic mem_hit;
    logic unused_fwd;
    assign mem_hit    = ex_mem_reg_write && ex_mem_rd != '0 && (ex_mem_rd == id_rs1 || ex_mem_rd == id_rs2);
    assign hazard     = id_valid && ((ex_hit && s.ctrl.reg_write) || mem_hit);
    assign rs1_fwd    = s.rs1_data;
    assign rs2_fwd    = s.rs2_data;
    assign unused_fwd = ^{ex_mem_result, mem_wb_rd, mem_wb_reg_write, mem_wb_result, s.rs1, s.rs2};
`endif

    assign alu_in1       = rs1_fwd;
    assign alu_in2       = s.alu_src ? s.imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;
    assign alu_sel       = s.alu_sel;
    assign ex_valid      = s.valid;
    assign ex_rd         = s.rd;
    assign ex_reg_write  = s.ctrl.reg_write;
    assign ex_mem_read   = s.ctrl.mem_read;
    assign ex_mem_write  = s.ctrl.mem_write;
    assign ex_branch     = s.ctrl.branch;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage (both FORWARDING_EN builds).
module tb_id_ex_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic [4:0]  id_rs1, id_rs2, id_rd, ex_mem_rd, mem_wb_rd, ex_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, ex_mem_result, mem_wb_result;
    logic [3:0]  id_alu_sel, alu_sel;
    logic        stall, flush, ex_mem_reg_write, mem_wb_reg_write;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, hazard;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_sel(id_alu_sel), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch),
        .stall(stall), .flush(flush),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_result(ex_mem_result),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_result(mem_wb_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .hazard(hazard)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, r2, rd,
                         input logic [31:0] d1, d2, im, input logic [3:0] sel,
                         input logic src, rw, mr, mw, br);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = im;
        id_alu_sel = sel; id_alu_src = src;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_branch = br;
    endtask

    task automatic fwd(input logic [4:0] emrd, input logic emw, input logic [31:0] emr,
                       input logic [4:0] mwrd, input logic mww, input logic [31:0] mwr);
        ex_mem_rd = emrd; ex_mem_reg_write = emw; ex_mem_result = emr;
        mem_wb_rd = mwrd; mem_wb_reg_write = mww; mem_wb_result = mwr;
    endtask

    task automatic test_reset;
        logic [175:0] all_out;
        fwd(0, 0, 0, 0, 0, 0);
        stall = 0; flush = 0; rst = 1;
        drive(1, 1, 2, 3, 32'hA, 32'hB, 0, ALU_SUB, 0, 1, 0, 0, 0);
        tick; tick;
        all_out = {alu_in1, alu_in2, ex_store_data, alu_sel, ex_valid, ex_rd, ex_reg_write,
                   ex_mem_read, ex_mem_write, ex_branch, hazard, 64'h0, 15'h0};
        total++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h required 0", all_out);
        else passed++;
        rst = 0;
        tick;
        total++;
        if ({ex_valid, ex_rd, alu_sel, ex_reg_write} !== {1'b1, 5'd3, ALU_SUB, 1'b1})
            $display("FAIL first_instr_ctrl: got %b %0d %h %b required 1 3 1 1", ex_valid, ex_rd, alu_sel, ex_reg_write);
        else passed++;
        total++;
        if ({alu_in1, alu_in2, ex_store_data} !== {32'hA, 32'hB, 32'hB})
            $display("FAIL first_instr_data: got %h %h %h required a b b", alu_in1, alu_in2, ex_store_data);
        else passed++;
    endtask

    task automatic test_forward_priority;
        logic [31:0] e_both, e_wb;
        logic        e_haz;
`ifdef FORWARDING_EN
        e_both = 32'h22; e_wb = 32'h33; e_haz = 1'b0;
`else
        e_both = 32'h11; e_wb = 32'h11; e_haz = 1'b1;
`endif
        fwd(0, 0, 0, 0, 0, 0);
        drive(1, 5, 6, 9, 32'h11, 32'h66, 0, ALU_ADD, 0, 1, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        fwd(5, 1, 32'h22, 5, 1, 32'h33);
        #1;
        total++;
        if (alu_in1 !== e_both) $display("FAIL fwd_ex_mem_priority: got %h required %h", alu_in1, e_both);
        else passed++;
        total++;
        if (alu_in2 !== 32'h66) $display("FAIL fwd_no_match_rs2: got %h required 66", alu_in2);
        else passed++;
        fwd(5, 0, 32'h22, 5, 1, 32'h33);
        #1;
        total++;
        if (alu_in1 !== e_wb) $display("FAIL fwd_mem_wb: got %h required %h", alu_in1, e_wb);
        else passed++;
        drive(1, 5, 0, 1, 0, 0, 0, ALU_ADD, 0, 1, 0, 0, 0);
        fwd(5, 1, 32'h22, 0, 0, 0);
        #1;
        total++;
        if (hazard !== e_haz) $display("FAIL hazard_ex_mem_raw: got %b required %b", hazard, e_haz);
        else passed++;
        drive(0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
    endtask

    task automatic test_x0_guard;
        fwd(0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 3, 32'h5, 0, 0, ALU_ADD, 0, 1, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        fwd(0, 1, 32'hDEAD, 0, 1, 32'hBEEF);
        #1;
        total++;
        if ({alu_in2, ex_store_data} !== 64'h0)
            $display("FAIL x0_guard: got %h %h required 0 0", alu_in2, ex_store_data);
        else passed++;
        total++;
        if (alu_in1 !== 32'h5) $display("FAIL x0_rs1_data: got %h required 5", alu_in1);
        else passed++;
    endtask

    task automatic test_load_use;
        fwd(0, 0, 0, 0, 0, 0);
        drive(1, 2, 0, 7, 32'h100, 0, 4, ALU_ADD, 1, 1, 1, 0, 0);
        tick;
        total++;
        if ({ex_valid, ex_mem_read, ex_rd} !== {1'b1, 1'b1, 5'd7})
            $display("FAIL lw_loaded: got %b %b %0d required 1 1 7", ex_valid, ex_mem_read, ex_rd);
        else passed++;
        drive(1, 7, 8, 10, 0, 32'h3, 0, ALU_SUB, 0, 1, 0, 0, 0);
        #1;
        total++;
        if (hazard !== 1'b1) $display("FAIL load_use_hazard: got %b required 1", hazard);
        else passed++;
        tick;
        total++;
        if ({ex_valid, alu_sel, ex_reg_write, ex_mem_read} !== 7'b0)
            $display("FAIL load_use_bubble: got %b %h %b %b required 0 0 0 0", ex_valid, alu_sel, ex_reg_write, ex_mem_read);
        else passed++;
        fwd(7, 1, 32'h55, 0, 0, 0);
        #1;
`ifdef FORWARDING_EN
        total++;
        if (hazard !== 1'b0) $display("FAIL hazard_after_bubble: got %b required 0", hazard);
        else passed++;
        tick;
        fwd(0, 0, 0, 7, 1, 32'h77);
        #1;
`else
        total++;
        if (hazard !== 1'b1) $display("FAIL hazard_after_bubble: got %b required 1", hazard);
        else passed++;
        tick;
        total++;
        if (ex_valid !== 1'b0) $display("FAIL second_bubble: got %b required 0", ex_valid);
        else passed++;
        fwd(0, 0, 0, 7, 1, 32'h77);
        drive(1, 7, 8, 10, 32'h77, 32'h3, 0, ALU_SUB, 0, 1, 0, 0, 0);
        #1;
        total++;
        if (hazard !== 1'b0) $display("FAIL hazard_cleared: got %b required 0", hazard);
        else passed++;
        tick;
`endif
        total++;
        if ({ex_valid, alu_sel, alu_in1, alu_in2} !== {1'b1, ALU_SUB, 32'h77, 32'h3})
            $display("FAIL load_use_reload: got %b %h %h %h required 1 1 77 3", ex_valid, alu_sel, alu_in1, alu_in2);
        else passed++;
    endtask

    task automatic test_immediate;
        logic [31:0] e_st;
`ifdef FORWARDING_EN
        e_st = 32'h44;
`else
        e_st = 32'h9;
`endif
        fwd(0, 0, 0, 0, 0, 0);
        drive(1, 1, 4, 11, 32'h1, 32'h9, 32'hFFFFFFFC, ALU_ADD, 1, 1, 0, 1, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        fwd(4, 1, 32'h44, 0, 0, 0);
        #1;
        total++;
        if (alu_in2 !== 32'hFFFFFFFC) $display("FAIL imm_alu_in2: got %h required fffffffc", alu_in2);
        else passed++;
        total++;
        if (ex_store_data !== e_st) $display("FAIL imm_store_data: got %h required %h", ex_store_data, e_st);
        else passed++;
        total++;
        if (ex_mem_write !== 1'b1) $display("FAIL imm_mem_write: got %b required 1", ex_mem_write);
        else passed++;
    endtask

    task automatic test_stall_flush;
        fwd(0, 0, 0, 0, 0, 0);
        drive(1, 1, 2, 12, 32'hA1, 32'hA2, 0, ALU_OR, 0, 1, 1, 0, 0);
        tick;
        drive(1, 12, 0, 13, 32'hB1, 0, 0, ALU_AND, 0, 1, 0, 0, 1);
        stall = 1;
        #1;
        total++;
        if (hazard !== 1'b1) $display("FAIL stall_hazard_raised: got %b required 1", hazard);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if ({ex_valid, ex_rd, alu_sel, alu_in1, ex_mem_read} !== {1'b1, 5'd12, ALU_OR, 32'hA1, 1'b1})
                $display("FAIL stall_hold_%0d: got %b %0d %h %h required 1 12 4 a1", i, ex_valid, ex_rd, alu_sel, alu_in1);
            else passed++;
        end
        flush = 1;
        tick;
        total++;
        if ({ex_valid, alu_sel, ex_reg_write} !== 6'b0)
            $display("FAIL flush_over_stall: got %b %h %b required 0 0 0", ex_valid, alu_sel, ex_reg_write);
        else passed++;
        flush = 0; stall = 0;
        tick;
        total++;
        if ({ex_valid, ex_rd, alu_sel, ex_branch} !== {1'b1, 5'd13, ALU_AND, 1'b1})
            $display("FAIL after_flush_load: got %b %0d %h %b required 1 13 3 1", ex_valid, ex_rd, alu_sel, ex_branch);
        else passed++;
        stall = 1; rst = 1;
        tick;
        total++;
        if ({ex_valid, ex_rd, alu_sel} !== 10'b0)
            $display("FAIL rst_over_stall: got %b %0d %h required 0 0 0", ex_valid, ex_rd, alu_sel);
        else passed++;
        rst = 0; stall = 0;
    endtask

    task automatic test_invalid_slot;
        fwd(0, 0, 0, 0, 0, 0);
        drive(0, 1, 2, 14, 32'h1, 32'h2, 32'h3, ALU_SLT, 1, 1, 1, 1, 1);
        tick;
        total++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, alu_sel, ex_rd} !== 14'b0)
            $display("FAIL invalid_bubble: got %b %b %b %b %b %h %0d required all 0",
                     ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, alu_sel, ex_rd);
        else passed++;
        total++;
        if (hazard !== 1'b0) $display("FAIL invalid_no_hazard: got %b required 0", hazard);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_forward_priority;
        test_x0_guard;
        test_load_use;
        test_immediate;
        test_stall_flush;
        test_invalid_slot;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
